// File: rtl/poly_pkg.sv
// Shared types for the cubic polynomial pipeline and its result buffer.
package poly_pkg;
  localparam int POLY_RES_W = 6;
  typedef logic [POLY_RES_W-1:0] poly_res_t;
endpackage

// File: rtl/poly_result_buffer_if.sv
// Producer/consumer bus of the result buffer: pipeline input, consumer handshake, drop status.
interface poly_result_buffer_if
  import poly_pkg::*;
#(
  parameter int DATA_W = POLY_RES_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              overflow;
  logic              ovf_clr;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output in_valid, in_data, out_ready, ovf_clr,
    input  out_valid, out_data, level, full, overflow, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, ovf_clr,
    output out_valid, out_data, level, full, overflow, drop_cnt
  );
endinterface

// File: rtl/poly_sat_counter.sv
// Saturating up-counter with clear; an increment in the same cycle as clear wins and loads 1.
module poly_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      if (clr)         cnt_d = W'(1);
      else if (~&cnt_q) cnt_d = cnt_q + W'(1);
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/poly_result_buffer.sv
// In-order result FIFO behind the polynomial pipeline; never stalls the input,
// drops and counts results that arrive while full with no pop.
module poly_result_buffer
  import poly_pkg::*;
#(
  parameter int DATA_W = POLY_RES_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input logic                clk,
  input logic                rst,
  poly_result_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, pop, push, drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);
  assign pop   = !empty && bus.out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign push  = bus.in_valid && (!full || pop);
  assign drop  = bus.in_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; the empty gate on out_data hides stale contents.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= bus.in_data;
  end

  poly_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.ovf_clr),
    .inc (drop),
    .cnt (bus.drop_cnt)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr_q];
  assign bus.level     = level_q;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
endmodule
